// File: rtl/vc_mux_n_pipe.sv
// vc_mux_n_pipe: N-input select mux into a 2-entry FIFO; define VC_MUX_N_PIPE_DOMAIN_SCRUB_EN to drop cross-domain messages
module vc_mux_n_pipe #(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4,
  parameter int p_selbits = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         domain,
  input  logic [p_selbits-1:0]         sel,
  input  logic [p_ninputs*p_nbits-1:0] in_msg,
  input  logic [p_ninputs-1:0]         in_domain,
  input  logic [p_ninputs-1:0]         in_val,
  output logic [p_ninputs-1:0]         in_rdy,
  output logic [p_nbits-1:0]           out_msg,
  output logic                         out_domain,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [7:0]                   drop_cnt
);
  localparam logic [p_selbits:0] lp_n = p_selbits'(p_ninputs) == 0 ? {1'b1, p_selbits'(0)} : {1'b0, p_selbits'(p_ninputs)};
  logic [p_nbits+1:0] w_ch [2**p_selbits];
  logic [p_nbits:0]   r_mem [2];
  logic               r_wr, r_rd;
  logic [1:0]         r_cnt;
  logic               w_full, w_acc, w_enq, w_deq;
  genvar i;
  generate
    for (i = 0; i < 2**p_selbits; i++) begin : g_ch
      if (i < p_ninputs) begin : g_in
        assign w_ch[i]   = {in_val[i], in_domain[i], in_msg[i*p_nbits +: p_nbits]};
        assign in_rdy[i] = reset_n && !w_full && sel == p_selbits'(i);
      end else begin : g_pad
        assign w_ch[i] = '0;
      end
    end
  endgenerate
  assign w_full = r_cnt == 2'd2;
  assign w_acc  = ({1'b0, sel} < lp_n) && w_ch[sel][p_nbits+1] && !w_full;
  assign w_deq  = out_val && out_rdy;
`ifdef VC_MUX_N_PIPE_DOMAIN_SCRUB_EN
  logic       w_drop;
  logic [7:0] r_drop;
  assign w_drop   = w_acc && (w_ch[sel][p_nbits] != domain);
  assign w_enq    = w_acc && !w_drop;
  assign drop_cnt = r_drop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
`else
  assign w_enq    = w_acc;
  assign drop_cnt = '0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_enq) r_mem[r_wr] <= w_ch[sel][p_nbits:0];
      if (w_enq) r_wr <= ~r_wr;
      if (w_deq) r_rd <= ~r_rd;
      r_cnt <= r_cnt + 2'(w_enq) - 2'(w_deq);
    end
  end
  assign {out_domain, out_msg} = r_mem[r_rd];
  assign out_val = r_cnt != 2'd0;
endmodule

// File: tb/tb_vc_mux_n_pipe.sv
// tb_vc_mux_n_pipe: directed checks of vc_mux_n_pipe with 4 inputs and a 3-bit sel
module tb_vc_mux_n_pipe;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         domain;
  logic [2:0]   sel;
  logic [127:0] in_msg;
  logic [3:0]   in_domain, in_val, in_rdy;
  logic [31:0]  out_msg;
  logic         out_domain, out_val, out_rdy;
  logic [7:0]   drop_cnt;
  int total = 0, bad = 0;
  logic [2:0]  sels [3] = '{3'd0, 3'd1, 3'd3};
  logic [31:0] msgs [3] = '{32'hA, 32'hB, 32'hD};
  vc_mux_n_pipe #(.p_nbits(32), .p_ninputs(4), .p_selbits(3)) dut (
    .clk(clk), .reset_n(reset_n), .domain(domain), .sel(sel), .in_msg(in_msg),
    .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy), .out_msg(out_msg),
    .out_domain(out_domain), .out_val(out_val), .out_rdy(out_rdy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [2:0] s, input logic [3:0] v, input logic [31:0] m);
    @(negedge clk);
    sel = s;
    in_val = v;
    if (s < 3'd4) in_msg[s*32 +: 32] = m;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; domain = 1'b0; sel = 3'd0; in_msg = '0;
    in_domain = '0; in_val = '0; out_rdy = 1'b0;
    #2;
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk) reset_n = 1'b1;
    out_rdy = 1'b1;
    drive(3'd2, 4'b0100, 32'hCAFE0002);
    chk("t2_in_rdy", in_rdy, 4'b0100);
    chk("t2_empty", out_val, 0);
    step();
    chk("t2_out_val", out_val, 1);
    chk("t2_out_msg", out_msg, 32'hCAFE0002);
    drive(3'd2, 4'b0000, 32'hCAFE0002);
    step();
    chk("t2_drained", out_val, 0);
    for (int k = 0; k < 3; k++) begin
      drive(sels[k], 4'b0001 << sels[k], msgs[k]);
      step();
      chk("t3_val", out_val, 1);
      chk("t3_msg", out_msg, msgs[k]);
    end
    drive(3'd0, 4'b0000, 32'h0);
    step();
    chk("t3_drained", out_val, 0);
    out_rdy = 1'b0;
    drive(3'd0, 4'b0001, 32'h11);
    step();
    drive(3'd0, 4'b0001, 32'h22);
    step();
    chk("t4_head", out_msg, 32'h11);
    drive(3'd0, 4'b0001, 32'h33);
    chk("t4_full_rdy", in_rdy, 0);
    step();
    chk("t4_hold", out_msg, 32'h11);
    @(negedge clk) out_rdy = 1'b1;
    #1;
    chk("t4_full_deq_rdy", in_rdy, 0);
    step();
    chk("t4_second", out_msg, 32'h22);
    @(negedge clk);
    #1;
    chk("t4_refill_rdy", in_rdy, 4'b0001);
    step();
    chk("t4_third", out_msg, 32'h33);
    chk("t4_third_val", out_val, 1);
    drive(3'd0, 4'b0000, 32'h0);
    step();
    chk("t4_drained", out_val, 0);
    drive(3'd5, 4'b1111, 32'h0);
    chk("t5_in_rdy", in_rdy, 0);
    step();
    chk("t5_out_val", out_val, 0);
    in_domain = 4'b0010;
    for (int k = 0; k < 300; k++) begin
      drive(3'd1, 4'b0010, 32'h1000 + k);
      chk("t6_in_rdy", in_rdy, 4'b0010);
      step();
`ifdef VC_MUX_N_PIPE_DOMAIN_SCRUB_EN
      chk("t6_scrub_val", out_val, 0);
`else
      chk("t6_val", out_val, 1);
      chk("t6_msg", out_msg, 32'h1000 + k);
      chk("t6_dom", out_domain, 1);
`endif
    end
`ifdef VC_MUX_N_PIPE_DOMAIN_SCRUB_EN
    chk("t6_drop_sat", drop_cnt, 8'd255);
`else
    chk("t6_drop_zero", drop_cnt, 0);
`endif
    in_domain = 4'b0000;
    out_rdy = 1'b0;
    drive(3'd0, 4'b0001, 32'h44);
    step();
    drive(3'd0, 4'b0001, 32'h55);
    step();
    chk("t1_full_val", out_val, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_out_val", out_val, 0);
    chk("t1_in_rdy", in_rdy, 0);
    chk("t1_drop", drop_cnt, 0);
    chk("t1_out_msg", out_msg, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
